// File: rtl/sr_pkg.sv
// Shared definitions for the LED shift-register serializer: widths, FSM
// encoding and the legal HALF_PERIOD range.
package sr_pkg;

  localparam int SR_NBITS = 8;
  localparam int SR_BIT_W = 3;
  localparam int HP_MIN   = 1;
  localparam int HP_MAX   = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } sr_state_e;

  // Out-of-range HALF_PERIOD values are clamped so the timer stays well defined.
  function automatic logic [7:0] hp_reload(int hp);
    int c;
    c = (hp < HP_MIN) ? HP_MIN : ((hp > HP_MAX) ? HP_MAX : hp);
    return 8'(c - 1);
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Reloadable down-counter; expired is high once the count reaches zero, so a
// phase loaded with RELOAD lasts RELOAD+1 cycles.
module sr_phase_timer
  import sr_pkg::*;
#(
  parameter logic [7:0] RELOAD = 8'd3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/sr_serializer.sv
// Serializes an 8-bit LED pattern MSB first to an external shift register.
// Optional SR_SKIP_DUP_EN: a repeat of the last transferred value is consumed silently.
module sr_serializer
  import sr_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sr_val,
  input  logic       sr_go,
  output logic       sr_rdy,
  output logic       sr_data,
  output logic       sr_clk,
  output logic       sr_latch
);

  sr_state_e             state_q, state_d;
  logic [SR_NBITS-1:0]   shift_q, shift_d;
  logic [SR_BIT_W-1:0]   bit_q, bit_d;
  logic                  rdy_q, rdy_d;
  logic                  data_q, data_d;
  logic                  sclk_q, sclk_d;
  logic                  latch_q, latch_d;
  logic                  start;
  logic                  timer_load;
  logic                  expired;
`ifdef SR_SKIP_DUP_EN
  logic [SR_NBITS-1:0]   last_val_q, last_val_d;
  logic                  last_valid_q, last_valid_d;
`endif

  sr_phase_timer #(
    .RELOAD (hp_reload(HALF_PERIOD))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    start   = 1'b0;
`ifdef SR_SKIP_DUP_EN
    last_val_d   = last_val_q;
    last_valid_d = last_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sr_go && rdy_q) begin
`ifdef SR_SKIP_DUP_EN
          if (!(last_valid_q && (sr_val == last_val_q))) begin
            start        = 1'b1;
            last_val_d   = sr_val;
            last_valid_d = 1'b1;
          end
`else
          start = 1'b1;
`endif
        end
        if (start) begin
          state_d = SHIFT_LO;
          shift_d = sr_val;
          bit_d   = SR_BIT_W'(SR_NBITS - 1);
        end
      end
      SHIFT_LO: if (expired) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (expired) begin
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            shift_d = {shift_q[SR_NBITS-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH: if (expired) state_d = IDLE;
    endcase

    // Every state change restarts the phase timer.
    timer_load = (state_d != state_q);
    rdy_d      = (state_d == IDLE);
    sclk_d     = (state_d == SHIFT_HI);
    latch_d    = (state_d == LATCH);
    data_d     = shift_d[SR_NBITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      rdy_q        <= 1'b0;
      data_q       <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
`ifdef SR_SKIP_DUP_EN
      last_val_q   <= '0;
      last_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      rdy_q        <= rdy_d;
      data_q       <= data_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
`ifdef SR_SKIP_DUP_EN
      last_val_q   <= last_val_d;
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign sr_rdy   = rdy_q;
  assign sr_data  = data_q;
  assign sr_clk   = sclk_q;
  assign sr_latch = latch_q;

endmodule

// File: tb/tb_sr_serializer.sv
// Bench for sr_serializer: two instances (HALF_PERIOD 4 and 1) checked cycle by
// cycle against a frame timeline model; SR_SKIP_DUP_EN selects duplicate handling.
module tb_sr_serializer;

  localparam int HP0 = 4;
  localparam int HP1 = 1;

  logic       clk;
  logic       rst;
  logic [1:0] go;
  logic [7:0] val [2];
  logic [1:0] rdy;
  logic [1:0] sdata;
  logic [1:0] sclk;
  logic [1:0] latch;

  int n_checks;
  int n_fail;
  logic [7:0] last_sent [2];

  sr_serializer #(.HALF_PERIOD(HP0)) dut0 (
    .clk(clk), .rst(rst), .sr_val(val[0]), .sr_go(go[0]),
    .sr_rdy(rdy[0]), .sr_data(sdata[0]), .sr_clk(sclk[0]), .sr_latch(latch[0])
  );

  sr_serializer #(.HALF_PERIOD(HP1)) dut1 (
    .clk(clk), .rst(rst), .sr_val(val[1]), .sr_go(go[1]),
    .sr_rdy(rdy[1]), .sr_data(sdata[1]), .sr_clk(sclk[1]), .sr_latch(latch[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hp_of(input int d);
    return (d == 0) ? HP0 : HP1;
  endfunction

  // Expected {rdy, clk, latch, data} k cycles after acceptance: 16 half-period
  // phases alternating low/high per bit (MSB first), then one latch phase.
  function automatic logic [3:0] exp_out(input int hp, input logic [7:0] v, input int k);
    int p;
    int b;
    p = (k - 1) / hp;
    if (p < 16) begin
      b = p / 2;
      return {1'b0, ((p % 2) == 1), 1'b0, v[7-b]};
    end
    return {1'b0, 1'b0, 1'b1, v[0]};
  endfunction

  function automatic logic [7:0] rand_diff(input logic [7:0] x);
    logic [7:0] r;
    r = 8'($urandom);
    if (r == x) r = r + 8'd1;
    return r;
  endfunction

  task automatic wait_rdy(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rdy[d] === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    last_sent[0] = 8'h00;
    last_sent[1] = 8'h00;
  endtask

  task automatic do_frame(input int d, input logic [7:0] v, input bit keep_go,
                          input logic [7:0] mid_v);
    int hp;
    bit ok;
    logic [3:0] e;
    logic [3:0] o;
    logic [7:0] got;
    int nbits;
    int nlatch;
    logic prev_clk;
    hp = hp_of(d);
    val[d] = v;
    go[d]  = 1'b1;
    wait_rdy(d, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout dut%0d: sr_rdy stayed 0, required 1", d);
      go[d] = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep_go) go[d] = 1'b0;
    got = 8'h00; nbits = 0; nlatch = 0; prev_clk = 1'b0;
    for (int k = 1; k <= 17 * hp; k++) begin
      if (k == 5 * hp) val[d] = mid_v;
      e = exp_out(hp, v, k);
      o = {rdy[d], sclk[d], latch[d], sdata[d]};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_cycle dut%0d val=%h k=%0d: got rdy/clk/latch/data=%b required %b",
                 d, v, k, o, e);
      end
      if (sclk[d] === 1'b1 && prev_clk === 1'b0) begin
        got = {got[6:0], sdata[d]};
        nbits++;
      end
      prev_clk = sclk[d];
      if (latch[d] === 1'b1) nlatch++;
      @(negedge clk);
    end
    n_checks++;
    if (got !== v || nbits != 8) begin
      n_fail++;
      $display("FAIL shifted_bits dut%0d: got %h in %0d clocks, required %h in 8", d, got, nbits, v);
    end
    n_checks++;
    if (nlatch != hp) begin
      n_fail++;
      $display("FAIL latch_width dut%0d: got %0d cycles, required %0d", d, nlatch, hp);
    end
    o = {rdy[d], sclk[d], latch[d], 1'b0};
    n_checks++;
    if (o !== 4'b1000) begin
      n_fail++;
      $display("FAIL frame_end dut%0d: got rdy/clk/latch=%b required 100", d, o[3:1]);
    end
    last_sent[d] = v;
  endtask

  task automatic test_reset();
    logic [3:0] o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = {rdy[d], sclk[d], latch[d], sdata[d]};
      n_checks++;
      if (o !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %b required 0000", d, o);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rdy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL rdy_after_reset dut%0d: got %b required 1", d, rdy[d]);
      end
    end
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = {rdy[d], sclk[d], latch[d], sdata[d]};
        n_checks++;
        if (o !== 4'b1000) begin
          n_fail++;
          $display("FAIL idle_quiet dut%0d: got %b required 1000", d, o);
        end
      end
    end
  endtask

  task automatic test_basic();
    do_frame(0, 8'hA5, 1'b0, 8'h5A);
  endtask

  task automatic test_back_to_back();
    do_frame(0, 8'hC3, 1'b1, 8'h3C);
    do_frame(0, 8'h3C, 1'b0, 8'hFF);
  endtask

  task automatic test_half_period_one();
    do_frame(1, 8'h00, 1'b0, 8'hFF);
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] nxt;
    bit keep;
    for (int d = 0; d < 2; d++) begin
      v = rand_diff(last_sent[d]);
      for (int i = 0; i < 5; i++) begin
        nxt  = rand_diff(v);
        keep = (i < 4) ? 1'($urandom) : 1'b0;
        do_frame(d, v, keep, keep ? nxt : 8'($urandom));
        v = nxt;
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] o;
    bit ok;
    val[0] = 8'hFF;
    go[0]  = 1'b1;
    wait_rdy(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_accept: sr_rdy stayed 0, required 1");
    end
    @(negedge clk);
    go[0] = 1'b0;
    repeat (25) @(negedge clk);
    n_checks++;
    if (sclk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_bit3_lo: sr_clk=%b required 0", sclk[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    o = {rdy[0], sclk[0], latch[0], sdata[0]};
    n_checks++;
    if (o !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b required 0000", o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rdy_release: got %b required 1", rdy[0]);
    end
    repeat (17 * HP0 + 4) begin
      @(negedge clk);
      o = {rdy[0], sclk[0], latch[0], 1'b0};
      n_checks++;
      if (o !== 4'b1000) begin
        n_fail++;
        $display("FAIL abort_not_resumed: rdy/clk/latch=%b required 100", o[3:1]);
      end
    end
    last_sent[0] = 8'h00;
    last_sent[1] = 8'h00;
  endtask

  task automatic test_skip_dup();
    pulse_reset();
    do_frame(0, 8'h81, 1'b0, 8'h18);
`ifdef SR_SKIP_DUP_EN
    begin
      logic [2:0] o;
      bit ok;
      val[0] = 8'h81;
      go[0]  = 1'b1;
      wait_rdy(0, ok);
      @(negedge clk);
      go[0] = 1'b0;
      repeat (20 * HP0) begin
        o = {rdy[0], sclk[0], latch[0]};
        n_checks++;
        if (o !== 3'b100) begin
          n_fail++;
          $display("FAIL dup_consumed: rdy/clk/latch=%b required 100", o);
        end
        @(negedge clk);
      end
    end
`else
    do_frame(0, 8'h81, 1'b0, 8'h18);
`endif
    pulse_reset();
    do_frame(0, 8'h81, 1'b0, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    go       = 2'b00;
    val[0]   = 8'h00;
    val[1]   = 8'h00;
    last_sent[0] = 8'h00;
    last_sent[1] = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_half_period_one();
    test_random();
    test_reset_abort();
    test_skip_dup();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_serializer.md
SR_SERIALIZER -- requirements
Module: sr_serializer

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per half serial-clock period; legal range 1..255.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 sr_val  in  8  LED pattern to shift out; sampled only at acceptance.
REQ-005 sr_go  in  1  transfer request; held by the requester until it sees sr_rdy.
REQ-006 sr_rdy  out  1  high only in IDLE; a transfer is accepted on any cycle with sr_go and sr_rdy both high.
REQ-007 sr_data  out  1  serial data to the external shift register.
REQ-008 sr_clk  out  1  shift clock; the external register samples on its rising edge.
REQ-009 sr_latch  out  1  storage-register latch pulse, active-high.

Function
REQ-010 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-011 IDLE: sr_rdy=1, sr_clk=0, sr_latch=0. On acceptance: capture sr_val into shift_q, load bit counter to 7, go to SHIFT_LO.
REQ-012 Each phase lasts exactly HALF_PERIOD cycles, timed by a countdown reloaded on every state entry.
REQ-013 SHIFT_LO: sr_clk=0, sr_data=shift_q[7]; on expiry go to SHIFT_HI.
REQ-014 SHIFT_HI: sr_clk=1, sr_data unchanged. On expiry: if bit counter=0 go to LATCH; else shift shift_q left by one, decrement the counter, go to SHIFT_LO.
REQ-015 Bit order: MSB first; sr_val[7] is the first bit clocked out.
REQ-016 LATCH: sr_latch=1, sr_clk=0, sr_data holds the last bit; on expiry go to IDLE.
REQ-017 sr_rdy is low for exactly 17*HALF_PERIOD cycles per transfer: the first cycle after acceptance through the last LATCH cycle.
REQ-018 All outputs are registered or decoded directly from state; no combinational path from sr_go or sr_val to any output.
REQ-019 sr_go while busy: ignored. The request is not queued, and the requester's held sr_go is accepted on the first IDLE cycle.
REQ-020 sr_val changes while busy do not alter the bits being shifted.
REQ-021 Back-to-back transfers: with sr_go held high, the next acceptance occurs on the first IDLE cycle, with no extra idle gap.

Reset
REQ-022 While rst is high: state=IDLE, sr_rdy=0, sr_data=0, sr_clk=0, sr_latch=0, shift_q=0, counters=0.
REQ-023 sr_rdy rises on the first cycle after rst deasserts.
REQ-024 Reset during SHIFT_* or LATCH aborts the transfer on the next edge, with no latch pulse generated; the partial transfer is discarded and not resumed.

Configuration
REQ-025 Macro SR_SKIP_DUP_EN, when defined: the module keeps last_val (8 bits) and last_valid (1 bit), both cleared by rst.
REQ-026 With SR_SKIP_DUP_EN defined and last_valid=1, an accepted sr_val equal to last_val is consumed in that cycle and the module stays in IDLE: sr_rdy stays 1, with no sr_clk or sr_latch activity.
REQ-027 With SR_SKIP_DUP_EN defined, any other accepted value transfers normally and updates last_val and last_valid at acceptance.
REQ-028 Without SR_SKIP_DUP_EN, every acceptance produces a full transfer, and last_val/last_valid do not exist.

Structure
REQ-029 Shared package sr_pkg holds: SR_NBITS=8, the FSM state typedef/encoding, and the HALF_PERIOD legal-range constants.
REQ-030 One sub-module, sr_phase_timer (reloadable down-counter with expiry strobe), times all phases; the FSM and shifter stay in sr_serializer.

Verification
REQ-031 After rst deasserts: sr_rdy=1 on the next cycle; sr_clk, sr_latch and sr_data stay 0 with sr_go low.
REQ-032 HALF_PERIOD=4, sr_val=8'hA5, one sr_go pulse: sr_data sequence 1,0,1,0,0,1,0,1 sampled at sr_clk rises; 8 sr_clk pulses each 4 high/4 low; sr_latch high 4 cycles; sr_rdy low 68 cycles.
REQ-033 sr_go held high with sr_val changed to 8'h3C mid-transfer: first frame shifts 8'hA5; second frame (8'h3C) is accepted on the first IDLE cycle.
REQ-034 rst asserted during bit 3 of the 8'hFF frame: all outputs 0 on the next edge; no sr_latch pulse; sr_rdy=1 one cycle after release.
REQ-035 SR_SKIP_DUP_EN defined, 8'h81 sent twice: the first produces a full frame, the second produces no sr_clk edges and sr_rdy never drops. After rst, 8'h81 again produces a full frame.
REQ-036 HALF_PERIOD=1, 8'h00: transfer completes in 17 cycles, and sr_clk toggles every cycle during the shift phases.
